// File: rtl/mult_arbiter.sv
// Two-requester arbiter sharing one external 3x3 array multiplier (IDLE -> GRANT -> DONE).
// Define MULT_ARBITER_FIXED_PRIO_EN for fixed priority (requester 0 wins); default is round-robin.
module mult_arbiter #(
  parameter int STAGE_CYCLES = 1
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       req0,
  input  logic [2:0] a0,
  input  logic [2:0] b0,
  input  logic       req1,
  input  logic [2:0] a1,
  input  logic [2:0] b1,
  output logic [2:0] mx,
  output logic [2:0] my,
  input  logic [5:0] mp,
  output logic       gnt0,
  output logic       gnt1,
  output logic       done0,
  output logic       done1,
  output logic [5:0] p,
  output logic       busy
);

  typedef enum logic [1:0] {IDLE, GRANT, DONE} state_t;

  localparam logic [2:0] LAST_STAGE = 3'(STAGE_CYCLES - 1);

  state_t     r_state, w_state_nxt;
  logic [2:0] r_cnt, w_cnt_nxt;
  logic       r_owner, w_owner_nxt;
  logic [2:0] r_mx, w_mx_nxt;
  logic [2:0] r_my, w_my_nxt;
  logic [5:0] r_p, w_p_nxt;
  logic       r_gnt0, w_gnt0_nxt;
  logic       r_gnt1, w_gnt1_nxt;
  logic       r_done0, w_done0_nxt;
  logic       r_done1, w_done1_nxt;
  logic       w_win;
  logic       w_owner_req;

`ifdef MULT_ARBITER_FIXED_PRIO_EN
  assign w_win = ~req0;
`else
  // r_last names the requester that most recently completed; it loses the next contention.
  logic r_last;

  assign w_win = (req0 & req1) ? ~r_last : ~req0;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_last <= 1'b1;
    end else if (r_state == GRANT && w_state_nxt == DONE) begin
      r_last <= r_owner;
    end
  end
`endif

  assign w_owner_req = r_owner ? req1 : req0;

  always_comb begin
    w_state_nxt = r_state;
    w_cnt_nxt   = r_cnt;
    w_owner_nxt = r_owner;
    w_mx_nxt    = r_mx;
    w_my_nxt    = r_my;
    w_p_nxt     = r_p;
    w_gnt0_nxt  = 1'b0;
    w_gnt1_nxt  = 1'b0;
    w_done0_nxt = 1'b0;
    w_done1_nxt = 1'b0;
    case (r_state)
      IDLE: begin
        if (req0 | req1) begin
          w_state_nxt = GRANT;
          w_owner_nxt = w_win;
          w_cnt_nxt   = 3'd0;
          w_gnt0_nxt  = ~w_win;
          w_gnt1_nxt  = w_win;
          w_mx_nxt    = w_win ? a1 : a0;
          w_my_nxt    = w_win ? b1 : b0;
        end
      end
      GRANT: begin
        // A withdrawn request wins over completion, even on the final stage cycle.
        if (!w_owner_req) begin
          w_state_nxt = IDLE;
        end else if (r_cnt == LAST_STAGE) begin
          w_state_nxt = DONE;
          w_p_nxt     = mp;
          w_done0_nxt = ~r_owner;
          w_done1_nxt = r_owner;
        end else begin
          w_cnt_nxt  = r_cnt + 3'd1;
          w_gnt0_nxt = ~r_owner;
          w_gnt1_nxt = r_owner;
        end
      end
      DONE: begin
        w_state_nxt = IDLE;
      end
      default: begin
        w_state_nxt = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state <= IDLE;
      r_cnt   <= 3'd0;
      r_owner <= 1'b0;
      r_mx    <= 3'd0;
      r_my    <= 3'd0;
      r_p     <= 6'd0;
      r_gnt0  <= 1'b0;
      r_gnt1  <= 1'b0;
      r_done0 <= 1'b0;
      r_done1 <= 1'b0;
    end else begin
      r_state <= w_state_nxt;
      r_cnt   <= w_cnt_nxt;
      r_owner <= w_owner_nxt;
      r_mx    <= w_mx_nxt;
      r_my    <= w_my_nxt;
      r_p     <= w_p_nxt;
      r_gnt0  <= w_gnt0_nxt;
      r_gnt1  <= w_gnt1_nxt;
      r_done0 <= w_done0_nxt;
      r_done1 <= w_done1_nxt;
    end
  end

  assign mx    = r_mx;
  assign my    = r_my;
  assign p     = r_p;
  assign gnt0  = r_gnt0;
  assign gnt1  = r_gnt1;
  assign done0 = r_done0;
  assign done1 = r_done1;
  assign busy  = (r_state != IDLE);

endmodule

// File: tb/tb_mult_arbiter.sv
// Scoreboard bench for mult_arbiter: randomized operations against an arbitration/product model.
// The bench also plays the shared multiplier, so mp is simply mx*my.
module tb_mult_arbiter;

  localparam int STAGE = 3;

  logic       clk = 1'b0;
  logic       rst_n;
  logic       req0, req1;
  logic [2:0] a0, b0, a1, b1;
  logic [2:0] mx, my;
  logic [5:0] mp;
  logic       gnt0, gnt1, done0, done1, busy;
  logic [5:0] p;

  typedef struct {
    bit id;
    int prod;
  } exp_t;

  exp_t sbQ[$];
  int   total = 0;
  int   bad = 0;
  bit   lastServed = 1'b1;
  int   expP = 0;
  bit   prevDone0 = 1'b0;
  bit   prevDone1 = 1'b0;

  mult_arbiter #(.STAGE_CYCLES(STAGE)) dut (
    .clk(clk), .rst_n(rst_n),
    .req0(req0), .a0(a0), .b0(b0),
    .req1(req1), .a1(a1), .b1(b1),
    .mx(mx), .my(my), .mp(mp),
    .gnt0(gnt0), .gnt1(gnt1), .done0(done0), .done1(done1),
    .p(p), .busy(busy)
  );

  always #5 clk = ~clk;

  assign mp = 6'(int'(mx) * int'(my));

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    total++;
    if (actual !== expected) begin
      bad++;
      $display("[TB] FAIL %s: got %0d expected %0d at %0t", name, actual, expected, $time);
    end
  endtask

  // Who gets the multiplier when the request pattern r0/r1 is sampled.
  function automatic bit modelWinner(input bit r0, input bit r1);
    if (r0 && r1) begin
`ifdef MULT_ARBITER_FIXED_PRIO_EN
      return 1'b0;
`else
      return (lastServed == 1'b1) ? 1'b0 : 1'b1;
`endif
    end
    return r1 && !r0;
  endfunction

  // Entered at a negedge with the DUT idle. mode 0 = complete, 1 = withdraw in cycle 'at', 2 = reset in cycle 'at'.
  task automatic applyStimulus(input bit r0, input bit r1,
                               input logic [2:0] x0, input logic [2:0] y0,
                               input logic [2:0] x1, input logic [2:0] y1,
                               input int mode, input int at, input bit clearAfter);
    bit w;
    int ex, ey, prod;
    req0 = r0; req1 = r1; a0 = x0; b0 = y0; a1 = x1; b1 = y1;
    w = modelWinner(r0, r1);
    ex = w ? int'(x1) : int'(x0);
    ey = w ? int'(y1) : int'(y0);
    prod = ex * ey;
    if (mode == 0) sbQ.push_back('{id: w, prod: prod});
    for (int c = 1; c <= STAGE; c++) begin
      @(negedge clk);
      checkOutput("gnt0", gnt0, 32'(!w));
      checkOutput("gnt1", gnt1, 32'(w));
      checkOutput("mx", mx, ex);
      checkOutput("my", my, ey);
      checkOutput("busyGrant", busy, 1);
      checkOutput("pHeld", p, expP);
      if (mode != 0 && c == at) begin
        if (mode == 1) begin
          if (w) req1 = 1'b0; else req0 = 1'b0;
        end else begin
          rst_n = 1'b0;
        end
        break;
      end
    end
    @(negedge clk);
    if (mode == 0) begin
      checkOutput("doneOwner", w ? done1 : done0, 1);
      checkOutput("doneOther", w ? done0 : done1, 0);
      checkOutput("gntOffDone", {gnt0, gnt1}, 0);
      checkOutput("busyDone", busy, 1);
      checkOutput("pDone", p, prod);
      lastServed = w;
      expP = prod;
      if (clearAfter) begin req0 = 1'b0; req1 = 1'b0; end
      @(negedge clk);
      checkOutput("doneCleared", {done0, done1}, 0);
      checkOutput("busyIdle", busy, 0);
    end else if (mode == 1) begin
      checkOutput("abortGnt", {gnt0, gnt1}, 0);
      checkOutput("abortDone", {done0, done1}, 0);
      checkOutput("abortBusy", busy, 0);
      checkOutput("abortP", p, expP);
      req0 = 1'b0; req1 = 1'b0;
    end else begin
      checkOutput("rstGnt", {gnt0, gnt1}, 0);
      checkOutput("rstDone", {done0, done1}, 0);
      checkOutput("rstBusy", busy, 0);
      checkOutput("rstP", p, 0);
      checkOutput("rstMx", mx, 0);
      checkOutput("rstMy", my, 0);
      rst_n = 1'b1;
      req0 = 1'b0; req1 = 1'b0;
      expP = 0;
      lastServed = 1'b1;
    end
  endtask

  // Monitor: pops the scoreboard on every done pulse and checks the always-true invariants.
  always @(negedge clk) begin
    exp_t e;
    checkOutput("oneGnt", gnt0 & gnt1, 0);
    checkOutput("oneDone", done0 & done1, 0);
    if (prevDone0) checkOutput("done0Width", done0, 0);
    if (prevDone1) checkOutput("done1Width", done1, 0);
    if (done0 || done1) begin
      if (sbQ.size() == 0) begin
        checkOutput("unexpectedDone", {done0, done1}, 0);
      end else begin
        e = sbQ.pop_front();
        checkOutput("sbId", done1, 32'(e.id));
        checkOutput("sbProduct", p, e.prod);
      end
    end
    prevDone0 = done0;
    prevDone1 = done1;
  end

  initial begin
    #200000;
    bad++;
    $display("[TB] FAIL watchdog: got timeout expected finish at %0t", $time);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    bit r0, r1, hold;
    int mode, at, sel;
    logic [2:0] x0, y0, x1, y1;
    rst_n = 1'b0;
    req0 = 1'b0; req1 = 1'b0;
    a0 = 3'd0; b0 = 3'd0; a1 = 3'd0; b1 = 3'd0;
    @(negedge clk);
    @(negedge clk);
    checkOutput("resetGnt", {gnt0, gnt1}, 0);
    checkOutput("resetDone", {done0, done1}, 0);
    checkOutput("resetBusy", busy, 0);
    checkOutput("resetP", p, 0);
    checkOutput("resetMx", mx, 0);
    checkOutput("resetMy", my, 0);
    rst_n = 1'b1;
    $display("[TB] reset released, starting directed cases");

    applyStimulus(1, 1, 3'd2, 3'd3, 3'd7, 3'd7, 0, 0, 0);
    applyStimulus(1, 1, 3'd2, 3'd3, 3'd7, 3'd7, 0, 0, 1);
    applyStimulus(1, 0, 3'd3, 3'd5, 3'd0, 3'd0, 0, 0, 1);
    applyStimulus(0, 1, 3'd0, 3'd0, 3'd7, 3'd7, 0, 0, 1);
    applyStimulus(1, 0, 3'd4, 3'd4, 3'd0, 3'd0, 1, 1, 1);
    applyStimulus(1, 0, 3'd6, 3'd5, 3'd0, 3'd0, 1, STAGE, 1);
    applyStimulus(0, 1, 3'd0, 3'd0, 3'd5, 3'd3, 2, 2, 1);
    repeat (3) @(negedge clk);
    applyStimulus(1, 1, 3'd1, 3'd6, 3'd5, 3'd5, 0, 0, 1);

    $display("[TB] starting randomized operations");
    for (int i = 0; i < 60; i++) begin
      sel = int'($urandom_range(0, 2));
      r0 = (sel != 1);
      r1 = (sel != 0);
      x0 = 3'($urandom_range(0, 7)); y0 = 3'($urandom_range(0, 7));
      x1 = 3'($urandom_range(0, 7)); y1 = 3'($urandom_range(0, 7));
      sel = int'($urandom_range(0, 9));
      mode = (sel <= 6) ? 0 : ((sel <= 8) ? 1 : 2);
      at = int'($urandom_range(1, STAGE));
      hold = ($urandom_range(0, 3) == 0);
      if (mode == 0 && hold) begin
        applyStimulus(r0, r1, x0, y0, x1, y1, 0, 0, 0);
      end
      applyStimulus(r0, r1, x0, y0, x1, y1, mode, at, 1);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end

    repeat (4) @(negedge clk);
    checkOutput("sbEmpty", sbQ.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
